// File: rtl/jogo_pkg.sv
// Shared types and sizing for the guessing-game controller slice.
// Holds the FSM state encoding, datapath widths and parameter defaults.
package jogo_pkg;

  typedef enum logic [1:0] {
    ESPERA  = 2'd0,
    JOGANDO = 2'd1,
    GANHOU  = 2'd2,
    PERDEU  = 2'd3
  } estado_t;

  localparam int SENHA_W             = 6;
  localparam int TENT_W              = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int MAX_TENTATIVAS_DEF  = 7;

endpackage

// File: rtl/controle_jogo_if.sv
// Board-side signal bundle of the game controller: raw keys and switches in,
// hint-stage strobes and status out.
interface controle_jogo_if;
  import jogo_pkg::*;

  logic               key_start_n;
  logic               key_enter_n;
  logic [SENHA_W-1:0] sw_senha;
  logic [SENHA_W-1:0] sw_tentativa;
  logic               start;
  logic               enter;
  logic [TENT_W-1:0]  tentativas;
  logic               acertou;
  logic               esgotou;
  logic [1:0]         estado;

  modport master (
    output key_start_n, key_enter_n, sw_senha, sw_tentativa,
    input  start, enter, tentativas, acertou, esgotou, estado
  );

  modport slave (
    input  key_start_n, key_enter_n, sw_senha, sw_tentativa,
    output start, enter, tentativas, acertou, esgotou, estado
  );
endinterface

// File: rtl/debounce_tecla.sv
// Two-flop synchronizer plus stability counter for one active-low push-button.
// Emits a one-cycle press pulse on each accepted released-to-pressed change.
module debounce_tecla
  import jogo_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic [1:0]       fill_r;
  logic             stable_r;
  logic             stable_d_r;
  logic             armed_r;
  logic [CNT_W-1:0] cnt_r;
  logic             press_r;
  logic             differ_s;
  logic             at_max_s;

  assign differ_s = sync2_r ^ stable_r;
  assign at_max_s = (cnt_r == CNT_MAX);
  assign press    = press_r;

  // Synchronizer chain; fill_r marks when sync2_r carries a real key sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      fill_r  <= 2'b00;
    end else begin
      sync1_r <= key_n;
      sync2_r <= sync1_r;
      fill_r  <= {fill_r[0], 1'b1};
    end
  end

  // Stability counter: flip the accepted level after enough differing cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_r <= 1'b1;
      cnt_r    <= '0;
    end else if (differ_s) begin
      if (at_max_s) begin
        stable_r <= sync2_r;
        cnt_r    <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_r <= '0;
    end
  end

  // Press edge detect; a key held through reset must be seen released first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_d_r <= 1'b1;
      armed_r    <= 1'b0;
      press_r    <= 1'b0;
    end else begin
      stable_d_r <= stable_r;
      armed_r    <= armed_r | (fill_r[1] & sync2_r);
      press_r    <= armed_r & stable_d_r & ~stable_r;
    end
  end

endmodule

// File: rtl/controle_jogo.sv
// Game controller: debounces start/enter keys, locks the secret, counts guesses
// and drives the single-cycle strobes consumed by the hint stage.
module controle_jogo
  import jogo_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int MAX_TENTATIVAS  = MAX_TENTATIVAS_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  controle_jogo_if.slave  bus
);

  logic               press_start_s;
  logic               press_enter_s;
  estado_t            estado_r,   estado_nx_s;
  logic [SENHA_W-1:0] senha_r,    senha_nx_s;
  logic [TENT_W-1:0]  tent_r,     tent_nx_s;
  logic               acertou_r,  acertou_nx_s;
  logic               esgotou_r,  esgotou_nx_s;
  logic               start_r,    start_nx_s;
  logic               enter_r,    enter_nx_s;
  logic [TENT_W-1:0]  tent_inc_s;
  logic               acerto_s;
  logic               ultima_s;

  debounce_tecla #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_start (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (bus.key_start_n),
    .press (press_start_s)
  );

  debounce_tecla #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_enter (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (bus.key_enter_n),
    .press (press_enter_s)
  );

  assign tent_inc_s = tent_r + TENT_W'(1);
  assign acerto_s   = (bus.sw_tentativa == senha_r);
  assign ultima_s   = (tent_inc_s == TENT_W'(MAX_TENTATIVAS));

  // Next-state and strobe decode; a win outranks running out of guesses.
  always_comb begin
    estado_nx_s  = estado_r;
    senha_nx_s   = senha_r;
    tent_nx_s    = tent_r;
    acertou_nx_s = acertou_r;
    esgotou_nx_s = esgotou_r;
    start_nx_s   = 1'b0;
    enter_nx_s   = 1'b0;
    case (estado_r)
      ESPERA, GANHOU, PERDEU: begin
        if (press_start_s) begin
          senha_nx_s   = bus.sw_senha;
          tent_nx_s    = '0;
          acertou_nx_s = 1'b0;
          esgotou_nx_s = 1'b0;
          start_nx_s   = 1'b1;
          estado_nx_s  = JOGANDO;
        end else begin
          estado_nx_s = estado_r;
        end
      end
      JOGANDO: begin
        if (press_enter_s) begin
          enter_nx_s = 1'b1;
          tent_nx_s  = tent_inc_s;
          if (acerto_s) begin
            estado_nx_s  = GANHOU;
            acertou_nx_s = 1'b1;
          end else if (ultima_s) begin
            estado_nx_s  = PERDEU;
            esgotou_nx_s = 1'b1;
          end else begin
            estado_nx_s = JOGANDO;
          end
        end else begin
          estado_nx_s = JOGANDO;
        end
      end
      default: begin
        estado_nx_s = ESPERA;
      end
    endcase
  end

  // State, secret, guess counter, flags and strobes all update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_r  <= ESPERA;
      senha_r   <= '0;
      tent_r    <= '0;
      acertou_r <= 1'b0;
      esgotou_r <= 1'b0;
      start_r   <= 1'b0;
      enter_r   <= 1'b0;
    end else begin
      estado_r  <= estado_nx_s;
      senha_r   <= senha_nx_s;
      tent_r    <= tent_nx_s;
      acertou_r <= acertou_nx_s;
      esgotou_r <= esgotou_nx_s;
      start_r   <= start_nx_s;
      enter_r   <= enter_nx_s;
    end
  end

  assign bus.start      = start_r;
  assign bus.enter      = enter_r;
  assign bus.tentativas = tent_r;
  assign bus.acertou    = acertou_r;
  assign bus.esgotou    = esgotou_r;
  assign bus.estado     = estado_r;

endmodule

// File: tb/tb_controle_jogo.sv
// Directed bench for controle_jogo with DEBOUNCE_CYCLES=4, MAX_TENTATIVAS=3.
module tb_controle_jogo;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  controle_jogo_if bus ();

  controle_jogo #(.DEBOUNCE_CYCLES(4), .MAX_TENTATIVAS(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold the selected keys low for 12 cycles then release for 12, counting strobes.
  task automatic press_keys(input logic s, input logic e, output int ns, output int ne);
    ns = 0;
    ne = 0;
    bus.key_start_n = ~s;
    bus.key_enter_n = ~e;
    for (int i = 0; i < 24; i++) begin
      if (i == 12) begin
        bus.key_start_n = 1'b1;
        bus.key_enter_n = 1'b1;
      end
      @(posedge clk);
      #1;
      ns += int'(bus.start);
      ne += int'(bus.enter);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(5);
  endtask

  task automatic test_reset();
    int ns, ne;
    rst_n = 1'b0;
    #2;
    n_checks++; if (bus.start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %0h expected 0", bus.start); end
    n_checks++; if (bus.enter !== 1'b0) begin n_fail++; $display("FAIL reset_enter: got %0h expected 0", bus.enter); end
    n_checks++; if (bus.tentativas !== 4'd0) begin n_fail++; $display("FAIL reset_tent: got %0d expected 0", bus.tentativas); end
    n_checks++; if (bus.acertou !== 1'b0) begin n_fail++; $display("FAIL reset_acertou: got %0h expected 0", bus.acertou); end
    n_checks++; if (bus.esgotou !== 1'b0) begin n_fail++; $display("FAIL reset_esgotou: got %0h expected 0", bus.esgotou); end
    n_checks++; if (bus.estado !== 2'd0) begin n_fail++; $display("FAIL reset_estado: got %0d expected 0", bus.estado); end
    step(3);
    rst_n = 1'b1;
    step(5);
    press_keys(1'b0, 1'b1, ns, ne);
    n_checks++; if (ne !== 0) begin n_fail++; $display("FAIL espera_enter_ignored: got %0d pulses expected 0", ne); end
    n_checks++; if (bus.estado !== 2'd0) begin n_fail++; $display("FAIL espera_estado: got %0d expected 0", bus.estado); end
  endtask

  task automatic test_start_latency();
    int first, hi;
    first = 0;
    hi = 0;
    bus.sw_senha = 6'h2A;
    bus.key_start_n = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (bus.start === 1'b1) begin
        hi++;
        if (first == 0) first = k;
      end
    end
    n_checks++; if (first !== 8) begin n_fail++; $display("FAIL start_latency: got edge %0d expected 8", first); end
    n_checks++; if (hi !== 1) begin n_fail++; $display("FAIL start_width: got %0d cycles expected 1", hi); end
    n_checks++; if (bus.estado !== 2'd1) begin n_fail++; $display("FAIL start_estado: got %0d expected 1", bus.estado); end
    n_checks++; if (bus.tentativas !== 4'd0) begin n_fail++; $display("FAIL start_tent: got %0d expected 0", bus.tentativas); end
    bus.key_start_n = 1'b1;
    step(12);
  endtask

  task automatic test_glitch();
    int ne;
    ne = 0;
    bus.key_enter_n = 1'b0;
    step(2);
    bus.key_enter_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      ne += int'(bus.enter);
    end
    n_checks++; if (ne !== 0) begin n_fail++; $display("FAIL glitch_enter: got %0d pulses expected 0", ne); end
    n_checks++; if (bus.tentativas !== 4'd0) begin n_fail++; $display("FAIL glitch_tent: got %0d expected 0", bus.tentativas); end
  endtask

  task automatic test_win();
    int ns, ne;
    bus.sw_tentativa = 6'h15;
    press_keys(1'b0, 1'b1, ns, ne);
    n_checks++; if (ne !== 1) begin n_fail++; $display("FAIL win_enter1: got %0d pulses expected 1", ne); end
    n_checks++; if (bus.estado !== 2'd1) begin n_fail++; $display("FAIL win_estado1: got %0d expected 1", bus.estado); end
    bus.sw_tentativa = 6'h2A;
    press_keys(1'b0, 1'b1, ns, ne);
    n_checks++; if (ne !== 1) begin n_fail++; $display("FAIL win_enter2: got %0d pulses expected 1", ne); end
    n_checks++; if (bus.tentativas !== 4'd2) begin n_fail++; $display("FAIL win_tent: got %0d expected 2", bus.tentativas); end
    n_checks++; if (bus.acertou !== 1'b1) begin n_fail++; $display("FAIL win_acertou: got %0h expected 1", bus.acertou); end
    n_checks++; if (bus.estado !== 2'd2) begin n_fail++; $display("FAIL win_estado: got %0d expected 2", bus.estado); end
    n_checks++; if (bus.esgotou !== 1'b0) begin n_fail++; $display("FAIL win_esgotou: got %0h expected 0", bus.esgotou); end
  endtask

  task automatic test_lose();
    int ns, ne;
    logic [5:0] guesses [3];
    guesses = '{6'h00, 6'h01, 6'h02};
    press_keys(1'b1, 1'b0, ns, ne);
    n_checks++; if (ns !== 1) begin n_fail++; $display("FAIL lose_start: got %0d pulses expected 1", ns); end
    n_checks++; if (bus.acertou !== 1'b0) begin n_fail++; $display("FAIL lose_acertou_clr: got %0h expected 0", bus.acertou); end
    for (int g = 0; g < 3; g++) begin
      bus.sw_tentativa = guesses[g];
      press_keys(1'b0, 1'b1, ns, ne);
    end
    n_checks++; if (bus.tentativas !== 4'd3) begin n_fail++; $display("FAIL lose_tent: got %0d expected 3", bus.tentativas); end
    n_checks++; if (bus.esgotou !== 1'b1) begin n_fail++; $display("FAIL lose_esgotou: got %0h expected 1", bus.esgotou); end
    n_checks++; if (bus.estado !== 2'd3) begin n_fail++; $display("FAIL lose_estado: got %0d expected 3", bus.estado); end
    press_keys(1'b0, 1'b1, ns, ne);
    n_checks++; if (ne !== 0) begin n_fail++; $display("FAIL lose_extra_enter: got %0d pulses expected 0", ne); end
    n_checks++; if (bus.tentativas !== 4'd3) begin n_fail++; $display("FAIL lose_tent_hold: got %0d expected 3", bus.tentativas); end
  endtask

  task automatic test_restart();
    int ns, ne;
    bus.sw_senha = 6'h07;
    press_keys(1'b1, 1'b0, ns, ne);
    n_checks++; if (ns !== 1) begin n_fail++; $display("FAIL restart_start: got %0d pulses expected 1", ns); end
    n_checks++; if (bus.estado !== 2'd1) begin n_fail++; $display("FAIL restart_estado: got %0d expected 1", bus.estado); end
    n_checks++; if (bus.tentativas !== 4'd0) begin n_fail++; $display("FAIL restart_tent: got %0d expected 0", bus.tentativas); end
    n_checks++; if (bus.esgotou !== 1'b0) begin n_fail++; $display("FAIL restart_esgotou: got %0h expected 0", bus.esgotou); end
    bus.sw_tentativa = 6'h07;
    press_keys(1'b0, 1'b1, ns, ne);
    n_checks++; if (bus.estado !== 2'd2) begin n_fail++; $display("FAIL restart_win_estado: got %0d expected 2", bus.estado); end
    n_checks++; if (bus.acertou !== 1'b1) begin n_fail++; $display("FAIL restart_win_acertou: got %0h expected 1", bus.acertou); end
  endtask

  task automatic test_win_last();
    int ns, ne;
    press_keys(1'b1, 1'b0, ns, ne);
    bus.sw_tentativa = 6'h00;
    press_keys(1'b0, 1'b1, ns, ne);
    bus.sw_tentativa = 6'h01;
    press_keys(1'b0, 1'b1, ns, ne);
    bus.sw_tentativa = 6'h07;
    press_keys(1'b0, 1'b1, ns, ne);
    n_checks++; if (bus.tentativas !== 4'd3) begin n_fail++; $display("FAIL last_tent: got %0d expected 3", bus.tentativas); end
    n_checks++; if (bus.estado !== 2'd2) begin n_fail++; $display("FAIL last_estado: got %0d expected 2", bus.estado); end
    n_checks++; if (bus.esgotou !== 1'b0) begin n_fail++; $display("FAIL last_esgotou: got %0h expected 0", bus.esgotou); end
  endtask

  task automatic test_both_keys();
    int ns, ne;
    do_reset();
    bus.sw_senha = 6'h07;
    bus.sw_tentativa = 6'h00;
    press_keys(1'b1, 1'b1, ns, ne);
    n_checks++; if (ns !== 1) begin n_fail++; $display("FAIL both_espera_start: got %0d pulses expected 1", ns); end
    n_checks++; if (ne !== 0) begin n_fail++; $display("FAIL both_espera_enter: got %0d pulses expected 0", ne); end
    n_checks++; if (bus.estado !== 2'd1) begin n_fail++; $display("FAIL both_espera_estado: got %0d expected 1", bus.estado); end
    press_keys(1'b1, 1'b1, ns, ne);
    n_checks++; if (ns !== 0) begin n_fail++; $display("FAIL both_jog_start: got %0d pulses expected 0", ns); end
    n_checks++; if (ne !== 1) begin n_fail++; $display("FAIL both_jog_enter: got %0d pulses expected 1", ne); end
    n_checks++; if (bus.tentativas !== 4'd1) begin n_fail++; $display("FAIL both_jog_tent: got %0d expected 1", bus.tentativas); end
  endtask

  task automatic test_reset_mid_round();
    int ns, ne;
    press_keys(1'b0, 1'b1, ns, ne);
    n_checks++; if (bus.tentativas !== 4'd2) begin n_fail++; $display("FAIL mid_pre_tent: got %0d expected 2", bus.tentativas); end
    n_checks++; if (bus.estado !== 2'd1) begin n_fail++; $display("FAIL mid_pre_estado: got %0d expected 1", bus.estado); end
    bus.key_start_n = 1'b0;
    step(1);
    rst_n = 1'b0;
    #2;
    n_checks++; if (bus.tentativas !== 4'd0) begin n_fail++; $display("FAIL mid_async_tent: got %0d expected 0", bus.tentativas); end
    n_checks++; if (bus.estado !== 2'd0) begin n_fail++; $display("FAIL mid_async_estado: got %0d expected 0", bus.estado); end
    n_checks++; if ({bus.start, bus.enter, bus.acertou, bus.esgotou} !== 4'b0000) begin
      n_fail++; $display("FAIL mid_async_flags: got %4b expected 0000", {bus.start, bus.enter, bus.acertou, bus.esgotou});
    end
    step(3);
    rst_n = 1'b1;
    ns = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      ns += int'(bus.start);
    end
    n_checks++; if (ns !== 0) begin n_fail++; $display("FAIL held_no_start: got %0d pulses expected 0", ns); end
    bus.key_start_n = 1'b1;
    step(12);
    press_keys(1'b1, 1'b0, ns, ne);
    n_checks++; if (ns !== 1) begin n_fail++; $display("FAIL held_repress_start: got %0d pulses expected 1", ns); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b1;
    bus.key_start_n = 1'b1;
    bus.key_enter_n = 1'b1;
    bus.sw_senha = 6'h00;
    bus.sw_tentativa = 6'h00;
    test_reset();
    test_start_latency();
    test_glitch();
    test_win();
    test_lose();
    test_restart();
    test_win_last();
    test_both_keys();
    test_reset_mid_round();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
